// File: rtl/fix_ari_mul_seq.sv
// Sequential signed fixed-point multiplier (Q12.16 by default).
// Operands are reduced to sign + magnitude and multiplied with a radix-2
// shift-add loop, one multiplier bit per cycle (LSB first). The magnitude is
// then rounded half-up, which gives half-away-from-zero rounding once the
// sign is applied. It is also saturated to the symmetric range [MIN, MAX].
// A single operation is in flight at a time, with valid/ready handshakes on
// both sides.
module fix_ari_mul_seq #(
  parameter int                      DATA = 29,
  parameter int                      INTE = 12,
  parameter int                      POIN = 16,
  parameter logic signed [DATA-1:0]  MIN  = 29'sh10000001,
  parameter logic signed [DATA-1:0]  MAX  = 29'sh0FFFFFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DATA-1:0] data_in1,
  input  logic signed [DATA-1:0] data_in2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [DATA-1:0] data_out,
  output logic                   ovf
);

  // The Q format only makes sense when sign + integer + fraction fill the word.
  generate
    if (DATA != 1 + INTE + POIN) begin : g_bad_width
      $error("fix_ari_mul_seq: DATA must equal 1+INTE+POIN");
    end
  endgenerate

  localparam int AW = 2 * DATA;           // accumulator width, holds |a|*|b|
  localparam int CW = $clog2(DATA + 1);   // counter also reaches DATA safely

  // Rounding constant: one half LSB of the Q-format result.
  localparam logic [AW-1:0] RND     = AW'(1) << (POIN - 1);
  // MAX is positive, so zero extension gives its full-width magnitude.
  localparam logic [AW-1:0] MAX_EXT = {{DATA{1'b0}}, MAX};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                   state_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic signed [DATA-1:0]   data_out_q;
  logic                     ovf_q;
  logic                     sign_q;
  logic        [DATA-1:0]   mcand_q;
  logic        [DATA-1:0]   mplier_q;
  logic        [AW-1:0]     acc_q;
  logic        [CW-1:0]     cnt_q;

  logic        [DATA-1:0]   mag1_d;
  logic        [DATA-1:0]   mag2_d;
  logic        [AW-1:0]     pp_d;
  logic        [AW-1:0]     acc_d;
  logic        [AW-1:0]     rsum_d;
  logic        [AW-1:0]     rmag_d;
  logic                     sat_d;
  logic signed [DATA-1:0]   res_d;

  // Operand magnitudes. The most negative input (-2^(DATA-1)) negates to its
  // own bit pattern, which read unsigned is exactly the right magnitude.
  always_comb begin
    mag1_d = data_in1;
    mag2_d = data_in2;
    if (data_in1[DATA-1]) mag1_d = $unsigned(-data_in1);
    if (data_in2[DATA-1]) mag2_d = $unsigned(-data_in2);
  end

  // Shift-add step: add the multiplicand weighted by the current bit position.
  always_comb begin
    pp_d  = {{DATA{1'b0}}, mcand_q} << cnt_q;
    acc_d = acc_q;
    if (mplier_q[cnt_q]) acc_d = acc_q + pp_d;
  end

  // Round the magnitude at full width, then saturate and apply the sign.
  // Comparing before any truncation means huge products cannot wrap into
  // the legal range.
  always_comb begin
    rsum_d = acc_q + RND;
    rmag_d = rsum_d >> POIN;
    sat_d  = (rmag_d > MAX_EXT);
    res_d  = $signed(rmag_d[DATA-1:0]);
    if (sign_q) res_d = -$signed(rmag_d[DATA-1:0]);
    if (sat_d)  res_d = sign_q ? MIN : MAX;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      ovf_q       <= 1'b0;
      sign_q      <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            sign_q     <= data_in1[DATA-1] ^ data_in2[DATA-1];
            mcand_q    <= mag1_d;
            mplier_q   <= mag2_d;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DATA - 1)) state_q <= FIN;
        end
        FIN: begin
          data_out_q  <= res_d;
          ovf_q       <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // The result stays held until the consumer takes it. Ready for the
          // next operand returns on the same edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fix_ari_mul_seq.sv
// Scoreboard bench for fix_ari_mul_seq: directed Q12.16 cases plus random
// streams, checked against a plain-integer arithmetic reference model.
module tb_fix_ari_mul_seq;
  localparam int          LAT  = 30;
  localparam logic [28:0] MAXV = 29'h0FFFFFFF;
  localparam logic [28:0] MINV = 29'h10000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [28:0] data_in1 = '0;
  logic [28:0] data_in2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [28:0] data_out;
  logic        ovf;

  typedef struct packed {
    logic [28:0] d;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rdy_mode = 0;
  logic prev_ov = 1'b0;

  fix_ari_mul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in1(data_in1), .data_in2(data_in2),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Random consumer backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference: exact integer product, magnitude rounded half-up, then clamp.
  function automatic exp_t model(input logic [28:0] a, input logic [28:0] b);
    longint sa, sb, p, m, r;
    bit     neg;
    exp_t   e;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    neg = (sa < 0) != (sb < 0);
    p   = sa * sb;
    m   = (p < 0) ? -p : p;
    r   = (m + 64'sd32768) / 65536;
    e.o = 1'b0;
    if (r > 268435455) begin
      e.o = 1'b1;
      r   = 268435455;
    end
    if (neg) r = -r;
    e.d = r[28:0];
    return e;
  endfunction

  function automatic logic [28:0] rnd_op();
    logic [28:0] v;
    int          s;
    case ($urandom_range(0, 3))
      0: v = 29'($urandom);
      1: begin s = int'($urandom_range(0, 2 ** 21)) - 2 ** 20; v = 29'(s); end
      2: begin s = int'($urandom_range(0, 2 ** 18)) - 2 ** 17; v = 29'(s); end
      default: begin
        case ($urandom_range(0, 4))
          0: v = MAXV;
          1: v = MINV;
          2: v = 29'h10000000;
          3: v = 29'h10000;
          default: v = '0;
        endcase
      end
    endcase
    return v;
  endfunction

  // Present an operand pair and wait for acceptance; called at posedge+#1.
  task automatic issue(input logic [28:0] a, input logic [28:0] b,
                       input logic [28:0] ed, input logic eo,
                       input bit push, input bit keep);
    bit   got = 0;
    exp_t e;
    data_in1 = a;
    data_in2 = b;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        acc_cyc = cyc + 1;
        if (push) begin
          e.d = ed;
          e.o = eo;
          q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: latency on each rising out_valid, scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) chk("latency", 64'(cyc - acc_cyc), 64'(LAT));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got=%0h want=none", data_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data_out", 64'(data_out), 64'(e.d));
          chk("ovf", 64'(ovf), 64'(e.o));
        end
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [28:0] a, b, hd;
    logic        ho;
    exp_t        e;
    bit          seen;

    // Reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed products, rounding and saturation
    rdy_mode = 0;
    out_ready = 1'b1;
    issue(29'h18000,    29'h20000,    29'h30000,    1'b0, 1, 0);
    issue(29'h1FFE8000, 29'h20000,    29'h1FFD0000, 1'b0, 1, 0);
    issue(29'h00001,    29'h08000,    29'h00001,    1'b0, 1, 0);
    issue(29'h1FFFFFFF, 29'h08000,    29'h1FFFFFFF, 1'b0, 1, 0);
    issue(29'h00001,    29'h00001,    29'h0,        1'b0, 1, 0);
    issue(29'h00001,    29'h07FFF,    29'h0,        1'b0, 1, 0);
    issue(MAXV,         MAXV,         MAXV,         1'b1, 1, 0);
    issue(29'h10000000, 29'h10000,    MINV,         1'b1, 1, 0);
    issue(29'h10000000, 29'h1FFF0000, MAXV,         1'b1, 1, 0);
    drain(200);

    // Backpressure: result held, input side closed, in_valid pulses ignored
    rdy_mode = 2;
    out_ready = 1'b0;
    issue(29'h1FFE8000, 29'h18000, 29'h1FFDC000, 1'b0, 1, 0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("bp_out_valid_seen", 64'(seen), 64'd1);
    hd = data_out;
    ho = ovf;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'(i % 2);
      data_in1 = rnd_op();
      data_in2 = rnd_op();
      @(negedge clk);
      chk("bp_data_stable", 64'(data_out), 64'(hd));
      chk("bp_ovf_stable", 64'(ovf), 64'(ho));
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_valid_high", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    drain(50);

    // Reset in the middle of MUL aborts the operation
    issue(29'h18000, 29'h20000, 29'h0, 1'b0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_in_ready_in_rst", 64'(in_ready), 64'd1);
    chk("abort_out_valid_in_rst", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("abort_no_output", 64'(seen), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back random stream, in_valid held high, random out_ready
    rdy_mode = 1;
    for (int n = 0; n < 20; n++) begin
      a = rnd_op();
      b = rnd_op();
      e = model(a, b);
      issue(a, b, e.d, e.o, 1, 1);
    end
    in_valid = 1'b0;
    drain(3000);
    rdy_mode = 0;
    out_ready = 1'b1;

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fix_ari_mul_seq.md
Name: fix_ari_mul_seq

Overview:
- Sequential signed fixed-point multiplier in Q12.16 (29-bit) format.
- Sits directly upstream of the saturating fixed-point adder. Its rounded, saturated products feed that adder's data_in1/data_in2.
- Radix-2 shift-add multiply over DATA cycles, then round-half-away-from-zero and symmetric saturation to the same [MIN, MAX] range the adder uses.
- valid/ready handshake on both sides; one operation in flight.

Parameters:
- DATA, 29, total word width; must equal 1+INTE+POIN.
- INTE, 12, integer bits.
- POIN, 16, fraction bits.
- MIN, 29'sb10000000000000000000000000001, most negative output (symmetric range, -2^28+1 LSB).
- MAX, 29'sb01111111111111111111111111111, most positive output (2^28-1 LSB).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- data_in1  input  DATA  signed multiplicand, Q12.16.
- data_in2  input  DATA  signed multiplier, Q12.16.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- data_out  output  DATA  signed rounded/saturated product, Q12.16.
- ovf  output  1  high with out_valid when data_out was saturated.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, data_out=0, ovf=0, all internal registers 0.
- Reset asserted mid-operation aborts the operation immediately. No result is produced. After release the block is in IDLE.
- States: IDLE, MUL, FIN, DONE.
- in_ready = (state==IDLE), registered-equivalent; no combinational path from in_valid.
- IDLE: an accept occurs at edge k when in_valid&in_ready.
  - Capture sign = data_in1[DATA-1]^data_in2[DATA-1].
  - Capture magnitudes |data_in1| and |data_in2| as DATA-bit unsigned. -2^28 maps to 2^28 with no overflow.
  - Clear the 2*DATA-bit accumulator and the counter. Go to MUL.
- MUL: one multiplier bit per cycle, LSB first.
  - If the current bit is 1, add the multiplicand shifted by the counter into the accumulator.
  - Counter increments. After DATA iterations (edge k+DATA) go to FIN.
- FIN, at edge k+DATA+1:
  - Rounded magnitude r = (acc + 2^(POIN-1)) >> POIN, computed at full width with no truncation before the compare.
  - If r > MAX: data_out = sign ? MIN : MAX, ovf=1.
  - Else: data_out = sign ? -r : r, ovf=0.
  - A zero result is 0 regardless of sign.
  - Set out_valid=1 and go to DONE.
- Latency: accept edge k to out_valid high at edge k+DATA+1 (30 cycles at defaults).
- DONE: data_out and ovf are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. in_ready rises on that same edge.
  - No new accept is possible in DONE.
  - Throughput: 1 result per DATA+3 cycles when out_ready is held high.
- in_valid and operand changes during MUL/FIN/DONE are ignored.
- Rounding is half away from zero, because it is applied to the magnitude before the sign.

Test Plan:
- Reset: rst_n low, then high. Required: in_ready=1, out_valid=0, data_out=0, ovf=0. Reset asserted again mid-MUL: out_valid never rises and in_ready returns to 1.
- Basic product: 29'h18000 (1.5) × 29'h20000 (2.0), out_ready=1. Required: out_valid at accept+30, data_out=29'h30000, ovf=0. Also 29'h1FFE8000 (-1.5) × 29'h20000 gives 29'h1FFD0000.
- Rounding: 29'h00001 × 29'h08000 gives 29'h00001. 29'h1FFFFFFF × 29'h08000 gives 29'h1FFFFFFF. 29'h00001 × 29'h00001 gives 0. 29'h00001 × 29'h07FFF gives 0.
- Saturation:
  - MAX × MAX gives MAX with ovf=1.
  - 29'h10000000 (-4096.0) × 29'h10000 (1.0) gives MIN (29'h10000001) with ovf=1.
  - 29'h10000000 × 29'h1FFF0000 (-1.0) gives MAX with ovf=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid. Required: data_out/ovf stable, in_ready=0, in_valid pulses ignored. Then out_ready=1: out_valid falls and in_ready rises on the same edge.
- Back-to-back: 20 random operand pairs streamed with in_valid held high and random out_ready. Required: results match a bit-exact reference model, in order, with no drops or duplicates.
